// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Purpose : shared sizing helpers, default parameter values and the read-mode
//           type used by the parametrised synchronous FIFO.
// Contents: addr_width()/cnt_width() sizing functions, DEF_* parameter
//           defaults, rd_mode_e (standard read vs first-word-fall-through).
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_AF_LVL = 14;
  localparam int DEF_AE_LVL = 2;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  // Address bits needed to index DEPTH entries.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// -----------------------------------------------------------------------------
// fifo_dpram
// Purpose : simple dual-port RAM, one write port and one read port with a
//           registered output. Written so synthesis infers block memory.
//           Read-during-write to the same address returns the old contents.
// Ports   : clk        rising-edge clock
//           i_wr_en    write enable
//           i_wr_addr  write address
//           i_wr_data  write data
//           i_rd_en    read enable (output register holds when low)
//           i_rd_addr  read address
//           o_rd_data  registered read data (no reset; contents undefined
//                      until written)
// -----------------------------------------------------------------------------
module fifo_dpram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Purpose : parametrised single-clock FIFO using every one of DEPTH entries,
//           with occupancy count, programmable almost flags, overflow /
//           underflow pulses and optional first-word-fall-through reads.
// Ports   : clk           rising-edge clock
//           reset_n       asynchronous active-low reset
//           sclr          synchronous clear (beats wren/rden)
//           wren, din     write request and data
//           rden          read request
//           dout          read data
//           full          count == DEPTH
//           empty         no word available to read
//           almost_full   count >= AF_LVL
//           almost_empty  count <= AE_LVL
//           count         words held (includes FWFT output register)
//           overflow      1-cycle pulse after a wren while full
//           underflow     1-cycle pulse after a rden while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL,
  parameter int FWFT   = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sclr,
  input  logic                        wren,
  input  logic [WIDTH-1:0]            din,
  input  logic                        rden,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LVL);

  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ram_we;
  logic              w_ram_rd_en;
  logic [ADDR_W-1:0] w_ram_rd_addr;
  logic [WIDTH-1:0]  w_ram_q;
  logic [PTR_W-1:0]  w_wr_ptr_next;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [CNT_W-1:0]  w_count_next;

  // Acceptance uses the registered flags, so a write to a full FIFO is
  // rejected even when a read frees a slot on the same edge.
  assign w_wr_acc = wren & ~r_full  & ~sclr;
  assign w_rd_acc = rden & ~r_empty & ~sclr;

  // count covers every word held, whether in RAM or the FWFT output register.
  assign w_count_next  = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
  assign w_wr_ptr_next = r_wr_ptr + PTR_W'(w_ram_we);

  fifo_dpram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (din),
    .i_rd_en   (w_ram_rd_en),
    .i_rd_addr (w_ram_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // Pointers, count and flags. Flags are computed from the next count and
  // registered, so nothing combinational reaches them from wren/rden.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else if (sclr) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_next;
      r_rd_ptr       <= w_rd_ptr_next;
      r_count        <= w_count_next;
      r_full         <= (w_count_next == C_DEPTH);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= C_AF);
      r_almost_empty <= (w_count_next <= C_AE);
      r_overflow     <= wren & r_full;
      r_underflow    <= rden & r_empty;
    end
  end

  generate
    if (MODE == RD_STANDARD) begin : gen_std
      // Forces dout to zero from reset/clear until the first accepted read,
      // so the uninitialised RAM output register is never visible.
      logic r_dout_clr;

      assign w_ram_we      = w_wr_acc;
      assign w_ram_rd_en   = w_rd_acc;
      assign w_ram_rd_addr = r_rd_ptr[ADDR_W-1:0];
      assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_rd_acc);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_dout_clr <= 1'b1;
        end else if (sclr) begin
          r_dout_clr <= 1'b1;
        end else if (w_rd_acc) begin
          r_dout_clr <= 1'b0;
        end
      end

      assign dout = r_dout_clr ? '0 : w_ram_q;
    end else begin : gen_fwft
      // The RAM holds only the words behind the output register; the output
      // register is valid exactly when the FIFO is not empty.
      logic [WIDTH-1:0] r_out_data;
      logic [WIDTH-1:0] r_fwd_data;
      logic             r_fwd_valid;
      logic             w_need_load;
      logic             w_mem_has;
      logic             w_load_mem;
      logic             w_load_byp;
      logic [WIDTH-1:0] w_head;

      assign w_mem_has   = (r_wr_ptr != r_rd_ptr);
      assign w_need_load = r_empty | w_rd_acc;
      assign w_load_mem  = w_need_load & w_mem_has & ~sclr;
      // Nothing queued in RAM: a write goes straight to the output register.
      assign w_load_byp  = w_need_load & ~w_mem_has & w_wr_acc;

      assign w_ram_we      = w_wr_acc & ~w_load_byp;
      assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_load_mem);

      // Read the future head address every cycle so the next word is already
      // sitting at the RAM output when the consumer pops.
      assign w_ram_rd_en   = 1'b1;
      assign w_ram_rd_addr = w_rd_ptr_next[ADDR_W-1:0];

      // A write landing on the address being prefetched returns stale RAM
      // data; the forwarded copy of din stands in for it.
      assign w_head = r_fwd_valid ? r_fwd_data : w_ram_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_out_data  <= '0;
          r_fwd_data  <= '0;
          r_fwd_valid <= 1'b0;
        end else if (sclr) begin
          r_out_data  <= '0;
          r_fwd_valid <= 1'b0;
        end else begin
          if (w_load_mem) begin
            r_out_data <= w_head;
          end else if (w_load_byp) begin
            r_out_data <= din;
          end
          r_fwd_valid <= w_ram_we &
                         (r_wr_ptr[ADDR_W-1:0] == w_rd_ptr_next[ADDR_W-1:0]);
          r_fwd_data  <= din;
        end
      end

      assign dout = r_out_data;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
